// File: rtl/ib_lut_pkg.sv
// Shared types for the ping-pong IB LUT memory.
// IB_LUT_PARITY_EN adds one even-parity bit to every stored entry.
package ib_lut_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} lut_state_e;

`ifdef IB_LUT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int LUT_QUAN_DEF = 3;
  localparam int LUT_ADDR_DEF = 5;

  typedef logic [LUT_QUAN_DEF-1:0] lut_data_t;
  typedef logic [LUT_ADDR_DEF-1:0] lut_addr_t;

endpackage

// File: rtl/ib_lut_bank_async.sv
// One LUT bank: synchronous write, READ_PORT_NUM asynchronous reads.
// Each read port owns a full copy of the array so every copy maps to a single-read LUTRAM.
module ib_lut_bank_async #(
  parameter int DATA_W              = 3,
  parameter int PAGE_NUM            = 32,
  parameter int ADDR_BITWIDTH       = 5,
  parameter int READ_PORT_NUM       = 4,
  parameter int XILINX_LUTRAM_INFER = 1
) (
  input  logic                                          write_clk,
  input  logic                                          we,
  input  logic [ADDR_BITWIDTH-1:0]                      waddr,
  input  logic [DATA_W-1:0]                             wdata,
  input  logic [READ_PORT_NUM-1:0][ADDR_BITWIDTH-1:0]   raddr,
  output logic [READ_PORT_NUM-1:0][DATA_W-1:0]          rdata
);

  localparam int IDX_W = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1;
  localparam logic [ADDR_BITWIDTH:0] PAGE_LIM = (ADDR_BITWIDTH+1)'(PAGE_NUM);

  genvar p;
  generate
    for (p = 0; p < READ_PORT_NUM; p++) begin : g_port
      logic in_range;
      assign in_range = {1'b0, raddr[p]} < PAGE_LIM;

      if (XILINX_LUTRAM_INFER != 0) begin : g_ram
        (* ram_style = "distributed" *) logic [DATA_W-1:0] mem [PAGE_NUM];
        always_ff @(posedge write_clk)
          if (we) mem[waddr[IDX_W-1:0]] <= wdata;
        assign rdata[p] = in_range ? mem[raddr[p][IDX_W-1:0]] : '0;
      end else begin : g_ram
        logic [DATA_W-1:0] mem [PAGE_NUM];
        always_ff @(posedge write_clk)
          if (we) mem[waddr[IDX_W-1:0]] <= wdata;
        assign rdata[p] = in_range ? mem[raddr[p][IDX_W-1:0]] : '0;
      end
    end
  endgenerate

endmodule

// File: rtl/ib_lut_mem_pingpong_loader.sv
// Double-buffered IB LUT: loader fills the shadow bank, swap makes it active.
// IB_LUT_PARITY_EN: entries carry even parity, read_parity_err_o flags mismatches.
module ib_lut_mem_pingpong_loader
  import ib_lut_pkg::*;
#(
  parameter int QUAN_SIZE           = 3,
  parameter int PAGE_NUM            = 32,
  parameter int ADDR_BITWIDTH       = 5,
  parameter int READ_PORT_NUM       = 4,
  parameter int XILINX_LUTRAM_INFER = 1
) (
  input  logic                               write_clk,
  input  logic                               rstn,
  input  logic [READ_PORT_NUM*ADDR_BITWIDTH-1:0] read_addr_i,
  output logic [READ_PORT_NUM*QUAN_SIZE-1:0] read_page_o,
  output logic [READ_PORT_NUM-1:0]           read_parity_err_o,
  input  logic                               load_start_i,
  input  logic                               load_valid_i,
  input  logic [QUAN_SIZE-1:0]               load_data_i,
  output logic                               load_ready_o,
  output logic                               load_done_o,
  input  logic                               swap_req_i,
  output logic                               swap_err_o,
  output logic                               active_sel_o
);

  localparam int W = QUAN_SIZE + PAR_W;
  localparam logic [ADDR_BITWIDTH-1:0] LAST = ADDR_BITWIDTH'(PAGE_NUM - 1);

  lut_state_e                 state, state_nxt;
  logic [ADDR_BITWIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic                       active_sel, sel_nxt;
  logic                       swap_err, swap_err_nxt;
  logic                       xfer;
  logic [W-1:0]               wdata;

  logic [READ_PORT_NUM-1:0][ADDR_BITWIDTH-1:0] raddr;
  logic [READ_PORT_NUM-1:0][W-1:0]             rd0, rd1, rsel;

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      active_sel <= 1'b0;
      swap_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      active_sel <= sel_nxt;
      swap_err   <= swap_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    sel_nxt      = active_sel;
    swap_err_nxt = 1'b0;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        swap_err_nxt = swap_req_i;
        if (load_start_i) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
        end
      end
      LOAD: begin
        swap_err_nxt = swap_req_i;
        // A restart takes priority over a transfer presented in the same cycle.
        if (load_start_i) begin
          wr_ptr_nxt = '0;
        end else if (load_valid_i) begin
          xfer = 1'b1;
          if (wr_ptr == LAST) begin
            state_nxt  = DONE;
            wr_ptr_nxt = '0;
          end else begin
            wr_ptr_nxt = wr_ptr + 1'b1;
          end
        end
      end
      DONE: begin
        if (swap_req_i) begin
          sel_nxt   = ~active_sel;
          state_nxt = IDLE;
        end else if (load_start_i) begin
          state_nxt  = LOAD;
          wr_ptr_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_ready_o = (state == LOAD);
  assign load_done_o  = (state == DONE);
  assign swap_err_o   = swap_err;
  assign active_sel_o = active_sel;

`ifdef IB_LUT_PARITY_EN
  assign wdata = {^load_data_i, load_data_i};
`else
  assign wdata = load_data_i;
`endif

  assign raddr = read_addr_i;

  // Only the shadow bank (~active_sel) ever sees a write strobe.
  ib_lut_bank_async #(
    .DATA_W(W), .PAGE_NUM(PAGE_NUM), .ADDR_BITWIDTH(ADDR_BITWIDTH),
    .READ_PORT_NUM(READ_PORT_NUM), .XILINX_LUTRAM_INFER(XILINX_LUTRAM_INFER)
  ) u_bank0 (
    .write_clk(write_clk), .we(xfer & active_sel), .waddr(wr_ptr), .wdata(wdata),
    .raddr(raddr), .rdata(rd0)
  );

  ib_lut_bank_async #(
    .DATA_W(W), .PAGE_NUM(PAGE_NUM), .ADDR_BITWIDTH(ADDR_BITWIDTH),
    .READ_PORT_NUM(READ_PORT_NUM), .XILINX_LUTRAM_INFER(XILINX_LUTRAM_INFER)
  ) u_bank1 (
    .write_clk(write_clk), .we(xfer & ~active_sel), .waddr(wr_ptr), .wdata(wdata),
    .raddr(raddr), .rdata(rd1)
  );

  assign rsel = active_sel ? rd1 : rd0;

  genvar p;
  generate
    for (p = 0; p < READ_PORT_NUM; p++) begin : g_out
      assign read_page_o[p*QUAN_SIZE +: QUAN_SIZE] = rsel[p][QUAN_SIZE-1:0];
`ifdef IB_LUT_PARITY_EN
      // Even parity: a clean word XORs to zero; out-of-range reads are all-zero.
      assign read_parity_err_o[p] = ^rsel[p];
`else
      assign read_parity_err_o[p] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ib_lut_mem_pingpong_loader.sv
// Directed bench for ib_lut_mem_pingpong_loader (ADDR_BITWIDTH=6 so out-of-range reads are reachable).
// IB_LUT_PARITY_EN enables the stored-bit corruption case.
module tb_ib_lut_mem_pingpong_loader;

  localparam int Q = 3;
  localparam int PN = 32;
  localparam int A = 6;
  localparam int P = 4;

  logic             write_clk = 1'b0;
  logic             rstn;
  logic [P*A-1:0]   read_addr_i;
  logic [P*Q-1:0]   read_page_o;
  logic [P-1:0]     read_parity_err_o;
  logic             load_start_i, load_valid_i, swap_req_i;
  logic [Q-1:0]     load_data_i;
  logic             load_ready_o, load_done_o, swap_err_o, active_sel_o;

  int n_tests = 0;
  int n_fail  = 0;

  ib_lut_mem_pingpong_loader #(
    .QUAN_SIZE(Q), .PAGE_NUM(PN), .ADDR_BITWIDTH(A), .READ_PORT_NUM(P), .XILINX_LUTRAM_INFER(1)
  ) dut (
    .write_clk(write_clk), .rstn(rstn),
    .read_addr_i(read_addr_i), .read_page_o(read_page_o), .read_parity_err_o(read_parity_err_o),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i), .load_data_i(load_data_i),
    .load_ready_o(load_ready_o), .load_done_o(load_done_o),
    .swap_req_i(swap_req_i), .swap_err_o(swap_err_o), .active_sel_o(active_sel_o)
  );

  always #5 write_clk = ~write_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2, input int a3);
    read_addr_i = {A'(a3), A'(a2), A'(a1), A'(a0)};
    #1;
  endtask

  // All ports read address a and must return exp.
  task automatic expect_page(input string tag, input int a, input int exp);
    set_addr(a, a, a, a);
    for (int p = 0; p < P; p++)
      chk($sformatf("%s_p%0d", tag, p), 32'(read_page_o[p*Q +: Q]), exp);
  endtask

  task automatic pulse_start();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
  endtask

  // Push n entries; data is (index+off)%8 when use_addr, else off.
  task automatic stream(input int n, input bit use_addr, input int off, input bit gaps);
    int cnt = 0;
    int guard = 0;
    bit x;
    while (cnt < n && guard < 2000) begin
      load_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data_i  = use_addr ? Q'((cnt + off) % 8) : Q'(off);
      x = load_valid_i && load_ready_o;
      tick();
      if (x) cnt++;
      guard++;
    end
    load_valid_i = 1'b0;
    if (guard >= 2000) chk("stream_timeout", cnt, n);
  endtask

  initial begin
    rstn = 1'b0;
    load_start_i = 1'b0; load_valid_i = 1'b0; swap_req_i = 1'b0;
    load_data_i = '0; read_addr_i = '0;

    // T1 reset state
    #12;
    chk("rst_active", active_sel_o, 0);
    chk("rst_ready",  load_ready_o, 0);
    chk("rst_done",   load_done_o,  0);
    chk("rst_swaperr", swap_err_o,  0);
    tick();
    rstn = 1'b1;
    tick();

    // valid in IDLE is ignored
    load_valid_i = 1'b1; load_data_i = 3'd6;
    tick(); tick();
    load_valid_i = 1'b0;
    chk("idle_ready", load_ready_o, 0);
    chk("idle_done",  load_done_o,  0);

    // T2 fill bank1 with addr%8 using random gaps, then swap
    pulse_start();
    chk("t2_ready", load_ready_o, 1);
    stream(PN, 1'b1, 0, 1'b1);
    chk("t2_done",  load_done_o, 1);
    chk("t2_ready_drop", load_ready_o, 0);
    chk("t2_pre_active", active_sel_o, 0);
    pulse_swap();
    chk("t2_active", active_sel_o, 1);
    chk("t2_swaperr", swap_err_o, 0);
    chk("t2_done_clr", load_done_o, 0);
    expect_page("t2_a5", 5, 5);
    expect_page("t2_a3", 3, 3);
    for (int i = 0; i < PN; i++) begin
      int ad [P];
      ad[0] = i; ad[1] = (i + 7) % PN; ad[2] = (i + 13) % PN; ad[3] = (i + 29) % PN;
      set_addr(ad[0], ad[1], ad[2], ad[3]);
      for (int p = 0; p < P; p++)
        chk($sformatf("t2_sweep_a%0d_p%0d", ad[p], p), 32'(read_page_o[p*Q +: Q]), ad[p] % 8);
      chk($sformatf("t2_par_%0d", i), 32'(read_parity_err_o), 0);
    end

    // T3 swap while IDLE and mid-LOAD is rejected
    pulse_swap();
    chk("t3_idle_err", swap_err_o, 1);
    chk("t3_idle_active", active_sel_o, 1);
    tick();
    chk("t3_idle_err_clr", swap_err_o, 0);
    pulse_start();
    stream(10, 1'b0, 0, 1'b0);
    pulse_swap();
    chk("t3_load_err", swap_err_o, 1);
    chk("t3_load_active", active_sel_o, 1);
    chk("t3_load_ready", load_ready_o, 1);
    tick();
    chk("t3_load_err_clr", swap_err_o, 0);

    // T4 restart after 20 transfers; the restart-cycle beat must be dropped
    stream(10, 1'b0, 0, 1'b0);
    load_valid_i = 1'b1; load_data_i = 3'd5; load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0; load_valid_i = 1'b0;
    stream(PN - 1, 1'b0, 7, 1'b0);
    chk("t4_done_early", load_done_o, 0);
    chk("t4_ready_31", load_ready_o, 1);
    expect_page("t4_old_a6", 6, 6);
    stream(1, 1'b0, 7, 1'b0);
    chk("t4_done", load_done_o, 1);
    pulse_swap();
    chk("t4_active", active_sel_o, 0);
    for (int i = 0; i < PN; i++)
      expect_page($sformatf("t4_a%0d", i), i, 7);

    // swap and start together in DONE: swap wins, FSM lands in IDLE
    pulse_start();
    stream(PN, 1'b1, 1, 1'b0);
    chk("t4b_done", load_done_o, 1);
    swap_req_i = 1'b1; load_start_i = 1'b1;
    tick();
    swap_req_i = 1'b0; load_start_i = 1'b0;
    chk("t4b_active", active_sel_o, 1);
    chk("t4b_ready", load_ready_o, 0);
    chk("t4b_done_clr", load_done_o, 0);
    expect_page("t4b_a4", 4, 5);
    expect_page("t4b_a31", 31, 0);

    // T5 async reset mid-load; shadow bank0 keeps partial data
    pulse_start();
    stream(15, 1'b0, 2, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    chk("t5_ready", load_ready_o, 0);
    chk("t5_done",  load_done_o,  0);
    chk("t5_active", active_sel_o, 0);
    expect_page("t5_a3", 3, 2);
    expect_page("t5_a20", 20, 7);
    expect_page("t5_a40", 40, 0);
    chk("t5_par", 32'(read_parity_err_o), 0);
    #2;
    rstn = 1'b1;
    tick();

`ifdef IB_LUT_PARITY_EN
    // T6 corrupt addr 9 in every read copy of the active bank
    dut.u_bank0.g_port[0].g_ram.mem[9] = dut.u_bank0.g_port[0].g_ram.mem[9] ^ 4'b0001;
    dut.u_bank0.g_port[1].g_ram.mem[9] = dut.u_bank0.g_port[1].g_ram.mem[9] ^ 4'b0001;
    dut.u_bank0.g_port[2].g_ram.mem[9] = dut.u_bank0.g_port[2].g_ram.mem[9] ^ 4'b0001;
    dut.u_bank0.g_port[3].g_ram.mem[9] = dut.u_bank0.g_port[3].g_ram.mem[9] ^ 4'b0001;
    set_addr(9, 3, 9, 40);
    chk("t6_par", 32'(read_parity_err_o), 32'b0101);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
